text_buffer_writer: RTL and testbench
=====================================

Name: text_buffer_writer

Overview:
- Initiator/writer side of the character-RAM interface; it drives the write port of the dual-port text RAM.
- Accepts a byte stream (UART RX or keyboard decoder) over a valid/ready handshake.
- Interprets printable characters and control codes, keeps a text cursor, and issues single-cycle RAM writes.
- Clears the screen and individual rows so the VGA reader port always sees valid space characters.

Parameters:
- DATA_SIZE, 8, RAM word width; character code in bits [7:0], upper bits written 0.
- ADDR_SIZE, 12, RAM address width; ROWS*COLS must be <= 2**ADDR_SIZE.
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- BLANK, 8'h20, fill character for clears.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a byte to consume.
- in_data  input  8  character or control code.
- in_ready  output  1  writer can accept a byte this cycle.
- ram_we  output  1  RAM write enable, one cycle per write.
- ram_addr  output  ADDR_SIZE  write address = row*COLS + col.
- ram_din  output  DATA_SIZE  write data.
- cur_col  output  $clog2(COLS)  cursor column.
- cur_row  output  $clog2(ROWS)  cursor row.
- busy  output  1  high during any clear sequence.

Behaviour:
- All outputs registered. Reset values: ram_we=0, ram_addr=0, ram_din=0, in_ready=0, cur_col=0, cur_row=0, busy=1. Next state after reset: CLR_ALL.
- Handshake: a byte is accepted when in_valid && in_ready. in_ready=1 only in IDLE. in_data is sampled at acceptance. After any acceptance in_ready is 0 for at least one cycle, so maximum throughput is 1 byte per 2 cycles.
- States:
  - CLR_ALL: write BLANK to addresses 0..ROWS*COLS-1, one address per cycle, ram_we=1 each cycle, busy=1. Then cursor = (0,0) and go to IDLE.
  - IDLE: in_ready=1, ram_we=0.
  - PUT: one cycle, ram_we=1 at the registered cursor address.
  - CLR_ROW: write BLANK to row*COLS .. row*COLS+COLS-1 for the new cursor row (COLS cycles, busy=1), then IDLE.
- Byte decode at acceptance (cycle N):
  - 0x20..0x7E: in cycle N+1, ram_we=1, ram_addr = old cursor address, ram_din = in_data. Cursor advances at the end of N+1. If col==COLS-1, col wraps to 0 and row advances; a row advance enters CLR_ROW. Otherwise return to IDLE.
  - 0x0A (LF): col=0, row advances, enter CLR_ROW; no character write.
  - 0x0D (CR): col=0; one idle cycle; no write.
  - 0x08 (BS): if col>0, col-1. Else if row>0, move to (row-1, COLS-1). At (0,0), cursor unchanged. Then PUT writes BLANK at the new cursor.
  - 0x0C (FF): enter CLR_ALL; cursor home.
  - Any other code: consumed and ignored; one cycle with in_ready=0; no write.
- Row advance: row==ROWS-1 wraps to row 0. There is no scrolling; the destination row is always cleared.
- cur_col/cur_row update in the same cycle the cursor register changes. During CLR_ROW they already show the new cursor.
- ram_addr arithmetic: row*COLS + col computed at full ADDR_SIZE width with no truncation for legal parameters. ram_din upper bits (DATA_SIZE>8) are 0.
- Reset asserted mid-sequence (any state): the next cycle shows the reset values, and the full CLR_ALL restarts from address 0. No partial write completes after reset.
- in_valid held high while in_ready=0: no byte is consumed, and in_data may change freely.

Test Plan:
- Reset 1 cycle, release -> ram_we=1 for exactly 2400 consecutive cycles, addresses 0..2399, din 0x20, busy=1; then in_ready=1, busy=0, cursor (0,0).
- Send 'A' (0x41) then 'B' -> writes 0x41@0 and 0x42@1, each one cycle after acceptance; cursor (2,0); in_ready low for the cycle after each accept.
- Cursor at (79,0), send 'Z' -> write 0x5A@79; cursor (0,1); CLR_ROW writes 0x20@80..159 over 80 cycles; then in_ready=1.
- Cursor (0,29), send 0x0A -> cursor (0,0); 0x20 written @0..79; no write at 2320.
- Cursor (0,1), send 0x08 -> cursor (79,0), write 0x20@79. At (0,0), 0x08 -> write 0x20@0, cursor stays (0,0). Then 0x07 -> no ram_we, cursor unchanged.
- Assert reset midway through a CLR_ROW, and also one cycle after accepting 'Q' -> the pending write is suppressed and CLR_ALL restarts at address 0.

Source files
------------

// File: rtl/text_buffer_writer.sv
`default_nettype none
// ============================================================================
// text_buffer_writer : byte-stream to character-RAM writer with cursor/clears
// Revision: 1.0
// ============================================================================
module text_buffer_writer #(
    parameter int          DATA_SIZE = 8,
    parameter int          ADDR_SIZE = 12,
    parameter int          COLS      = 80,
    parameter int          ROWS      = 30,
    parameter logic [7:0]  BLANK     = 8'h20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      ram_we,
    output logic [ADDR_SIZE-1:0]      ram_addr,
    output logic [DATA_SIZE-1:0]      ram_din,
    output logic [$clog2(COLS)-1:0]   cur_col,
    output logic [$clog2(ROWS)-1:0]   cur_row,
    output logic                      busy
);

    localparam int                   CW        = $clog2(COLS);
    localparam int                   RW        = $clog2(ROWS);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(ROWS * COLS - 1);
    localparam logic [ADDR_SIZE-1:0] LAST_CNT  = ADDR_SIZE'(COLS - 1);
    localparam logic [CW-1:0]        MAX_COL   = CW'(COLS - 1);
    localparam logic [RW-1:0]        MAX_ROW   = RW'(ROWS - 1);
    localparam logic [7:0]           CH_BS     = 8'h08;
    localparam logic [7:0]           CH_LF     = 8'h0A;
    localparam logic [7:0]           CH_FF     = 8'h0C;
    localparam logic [7:0]           CH_CR     = 8'h0D;

    // The state names the action taken at the next clock edge; the output
    // registers show the action taken at the previous edge.
    typedef enum logic [2:0] {
        S_CLR_ALL = 3'd0,
        S_IDLE    = 3'd1,
        S_PUT     = 3'd2,
        S_ADV     = 3'd3,
        S_CLR_ROW = 3'd4,
        S_WAIT    = 3'd5
    } state_t;

    state_t                 state, state_n;
    logic [ADDR_SIZE-1:0]   cnt, cnt_n;
    logic [CW-1:0]          col_n;
    logic [RW-1:0]          row_n, row_inc;
    logic                   we_n, ready_n, busy_n, accept, printable;
    logic [ADDR_SIZE-1:0]   addr_n;
    logic [DATA_SIZE-1:0]   din_n;

    function automatic logic [ADDR_SIZE-1:0] addr_of(input logic [RW-1:0] r,
                                                     input logic [ADDR_SIZE-1:0] c);
        return ADDR_SIZE'(r) * ADDR_SIZE'(COLS) + c;
    endfunction

    assign accept    = in_valid && in_ready;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign row_inc   = (cur_row == MAX_ROW) ? '0 : cur_row + RW'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        col_n   = cur_col;
        row_n   = cur_row;
        we_n    = 1'b0;
        addr_n  = ram_addr;
        din_n   = ram_din;
        ready_n = 1'b0;
        busy_n  = 1'b0;
        case (state)
            S_CLR_ALL: begin
                we_n   = 1'b1;
                addr_n = cnt;
                din_n  = DATA_SIZE'(BLANK);
                busy_n = 1'b1;
                if (cnt == LAST_ADDR) begin
                    cnt_n   = '0;
                    state_n = S_WAIT;
                end else begin
                    cnt_n = cnt + ADDR_SIZE'(1);
                end
            end
            S_WAIT: begin
                ready_n = 1'b1;
                state_n = S_IDLE;
            end
            S_IDLE: begin
                ready_n = 1'b1;
                if (accept) begin
                    ready_n = 1'b0;
                    state_n = S_WAIT;
                    if (printable) begin
                        we_n    = 1'b1;
                        addr_n  = addr_of(cur_row, ADDR_SIZE'(cur_col));
                        din_n   = DATA_SIZE'(in_data);
                        state_n = S_ADV;
                    end else begin
                        case (in_data)
                            CH_LF: begin
                                col_n   = '0;
                                row_n   = row_inc;
                                cnt_n   = '0;
                                busy_n  = 1'b1;
                                state_n = S_CLR_ROW;
                            end
                            CH_CR: col_n = '0;
                            CH_BS: begin
                                if (cur_col != '0) begin
                                    col_n = cur_col - CW'(1);
                                end else if (cur_row != '0) begin
                                    row_n = cur_row - RW'(1);
                                    col_n = MAX_COL;
                                end
                                state_n = S_PUT;
                            end
                            CH_FF: begin
                                col_n   = '0;
                                row_n   = '0;
                                cnt_n   = '0;
                                busy_n  = 1'b1;
                                state_n = S_CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_PUT: begin
                we_n    = 1'b1;
                addr_n  = addr_of(cur_row, ADDR_SIZE'(cur_col));
                din_n   = DATA_SIZE'(BLANK);
                state_n = S_WAIT;
            end
            S_ADV: begin
                if (cur_col == MAX_COL) begin
                    col_n   = '0;
                    row_n   = row_inc;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = S_CLR_ROW;
                end else begin
                    // Plain advance can re-open the handshake right away.
                    col_n   = cur_col + CW'(1);
                    ready_n = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_CLR_ROW: begin
                we_n   = 1'b1;
                addr_n = addr_of(cur_row, cnt);
                din_n  = DATA_SIZE'(BLANK);
                busy_n = 1'b1;
                if (cnt == LAST_CNT) begin
                    cnt_n   = '0;
                    state_n = S_WAIT;
                end else begin
                    cnt_n = cnt + ADDR_SIZE'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                busy_n  = 1'b1;
                state_n = S_CLR_ALL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_CLR_ALL;
            cnt      <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur_col  <= col_n;
            cur_row  <= row_n;
            ram_we   <= we_n;
            ram_addr <= addr_n;
            ram_din  <= din_n;
            in_ready <= ready_n;
            busy     <= busy_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_writer.sv
`default_nettype none
// ============================================================================
// tb_text_buffer_writer : random and directed bench with a screen/cursor model
// Revision: 1.0
// ============================================================================
module tb_text_buffer_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int TOTAL = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, ram_we, busy;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;

    text_buffer_writer #(
        .DATA_SIZE(8), .ADDR_SIZE(12), .COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: screen contents, cursor and the ordered list of expected writes.
    logic [7:0] mmem [TOTAL];
    int         mcol, mrow;
    int         exp_q[$];

    // Observed writes, collected away from the active edge.
    logic [7:0] shadow [TOTAL];
    int         act_q[$];

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            act_q.push_back(int'({ram_addr, ram_din}));
            if (ram_addr < TOTAL) shadow[ram_addr] = ram_din;
        end
    end

    function automatic void model_write(input int a, input int d);
        exp_q.push_back((a << 8) | d);
        mmem[a] = d[7:0];
    endfunction

    function automatic void model_clear_row(input int r);
        for (int c = 0; c < COLS; c++) model_write(r * COLS + c, 32);
    endfunction

    function automatic void model_reset();
        mcol = 0;
        mrow = 0;
        for (int a = 0; a < TOTAL; a++) mmem[a] = 8'h20;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            model_write(mrow * COLS + mcol, int'(b));
            mcol++;
            if (mcol == COLS) begin
                mcol = 0;
                mrow = (mrow + 1) % ROWS;
                model_clear_row(mrow);
            end
        end else if (b == 8'h0A) begin
            mcol = 0;
            mrow = (mrow + 1) % ROWS;
            model_clear_row(mrow);
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h08) begin
            if (mcol > 0) mcol--;
            else if (mrow > 0) begin
                mrow--;
                mcol = COLS - 1;
            end
            model_write(mrow * COLS + mcol, 32);
        end else if (b == 8'h0C) begin
            mcol = 0;
            mrow = 0;
            for (int a = 0; a < TOTAL; a++) model_write(a, 32);
        end
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 5000) begin
            in_data = 8'($urandom);
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check("send_timeout", 0, 1);
        in_data = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic compare_writes(input string tag);
        int errs = 0;
        int n;
        check({tag, "_nwr"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (act_q[i] != exp_q[i]) errs++;
        check({tag, "_wrseq"}, errs, 0);
        check({tag, "_col"}, cur_col, mcol);
        check({tag, "_row"}, cur_row, mrow);
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_mem(input string tag);
        int errs = 0;
        for (int a = 0; a < TOTAL; a++) if (shadow[a] !== mmem[a]) errs++;
        check(tag, errs, 0);
    endtask

    task automatic step(input logic [7:0] b, input string tag);
        model_byte(b);
        send(b);
        wait_ready(tag);
        compare_writes(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, ram_we, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_din"}, ram_din, 0);
        check({tag, "_rdy"}, in_ready, 0);
        check({tag, "_cur"}, {cur_row, cur_col}, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    // Reset is raised at the current negedge, held for one edge, then released.
    task automatic reset_and_recover(input string tag);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals(tag);
        reset = 1'b0;
        @(negedge clk);
        check({tag, "_restart"}, {ram_we, ram_addr}, {1'b1, 12'd0});
        wait_ready(tag);
        model_reset();
        act_q.delete();
        exp_q.delete();
        compare_mem({tag, "_mem"});
        check({tag, "_home"}, {cur_row, cur_col}, 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        logic [7:0] b;
        for (int a = 0; a < TOTAL; a++) shadow[a] = 8'hEE;

        // Power-up clear
        @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < TOTAL; i++) begin
            @(negedge clk);
            if (!(ram_we === 1'b1 && ram_addr === 12'(i) && ram_din === 8'h20 && busy === 1'b1))
                errs++;
        end
        check("clrall_seq", errs, 0);
        @(negedge clk);
        check("clrall_done", {in_ready, busy, ram_we}, {1'b1, 1'b0, 1'b0});
        check("clrall_cur", {cur_row, cur_col}, 0);
        model_reset();
        act_q.delete();
        compare_mem("clrall_mem");

        // 'A' then 'B' with write timing
        model_byte(8'h41);
        send(8'h41);
        check("A_wr", {ram_we, ram_addr, ram_din}, {1'b1, 12'd0, 8'h41});
        check("A_rdy", in_ready, 0);
        wait_ready("A");
        compare_writes("A");
        model_byte(8'h42);
        send(8'h42);
        check("B_wr", {ram_we, ram_addr, ram_din}, {1'b1, 12'd1, 8'h42});
        check("B_rdy", in_ready, 0);
        wait_ready("B");
        compare_writes("B");
        check("B_cur", {cur_row, cur_col}, {5'd0, 7'd2});

        for (int i = 0; i < 77; i++) step(8'($urandom_range(32, 126)), "fill");

        // End-of-row wrap into a row clear
        model_byte(8'h5A);
        send(8'h5A);
        check("Z_wr", {ram_we, ram_addr, ram_din}, {1'b1, 12'd79, 8'h5A});
        @(negedge clk);
        check("Z_cur", {cur_row, cur_col, busy}, {5'd1, 7'd0, 1'b1});
        wait_ready("Z");
        compare_writes("Z");

        // Backspace across a row edge and at home, then an ignored code
        step(8'h08, "bs_row");
        check("bs_row_cur", {cur_row, cur_col}, {5'd0, 7'd79});
        step(8'h0D, "cr");
        step(8'h08, "bs_home");
        check("bs_home_cur", {cur_row, cur_col}, 0);
        step(8'h07, "bel");

        // Line feed from the last row wraps to row 0 and leaves row 29 alone
        for (int i = 0; i < ROWS - 1; i++) step(8'h0A, "lf");
        step(8'h58, "X");
        step(8'h0D, "cr29");
        step(8'h0A, "lf_wrap");
        check("lf_wrap_cur", {cur_row, cur_col}, 0);
        compare_mem("lf_wrap_mem");

        // Randomized traffic
        for (int i = 0; i < 120; i++) begin
            int r;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 78) b = 8'h0A;
            else if (r < 84) b = 8'h0D;
            else if (r < 92) b = 8'h08;
            else if (r < 94) b = 8'h0C;
            else begin
                b = 8'($urandom_range(0, 255));
                while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0A || b == 8'h0D ||
                       b == 8'h08 || b == 8'h0C)
                    b = 8'($urandom_range(0, 255));
            end
            step(b, "rnd");
        end
        compare_mem("rnd_mem");

        // Reset in the middle of a row clear
        send(8'h0A);
        repeat (10) @(negedge clk);
        check("mid_clr_active", {busy, ram_we}, {1'b1, 1'b1});
        reset_and_recover("rst_clr");

        // Reset one cycle after accepting 'Q'
        step(8'h50, "P");
        send(8'h51);
        reset_and_recover("rst_q");

        step(8'h4B, "after_rst");
        compare_mem("final_mem");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
